// File: rtl/future_ts_release_if.sv
// Purpose : bundles the FIFO-head side and the release side of the time arbiter.
// Latency : none; this is wiring only.
// Backpressure: iREL_READY throttles the release side and the FIFO is popped only on capture.
// Signals : iFUTURE_TS/iFTS_VALID come from the FIFO head, and oTS_FIFO_POP returns to the FIFO.
//           oREL_VALID/oREL_TS/oREL_TAG/iREL_READY form the ready/valid release channel.
// Modports: master is the arbiter side, and slave is the FIFO/scheduler environment side.
interface future_ts_release_if;
  logic [107:0] iFUTURE_TS;
  logic         iFTS_VALID;
  logic         oTS_FIFO_POP;
  logic         oREL_VALID;
  logic [43:0]  oREL_TS;
  logic [63:0]  oREL_TAG;
  logic         iREL_READY;

  modport master (
    input  iFUTURE_TS, iFTS_VALID, iREL_READY,
    output oTS_FIFO_POP, oREL_VALID, oREL_TS, oREL_TAG
  );

  modport slave (
    output iFUTURE_TS, iFTS_VALID, iREL_READY,
    input  oTS_FIFO_POP, oREL_VALID, oREL_TS, oREL_TAG
  );
endinterface

// File: rtl/future_ts_release.sv
// Purpose : holds the FIFO head entry until local time reaches its release time, then hands it downstream.
// Latency : a due entry seen in WAIT appears on oREL_VALID/oTS_FIFO_POP one cycle later (registered).
// Backpressure: the released entry is held stable until iREL_READY, and after each pop the FIFO valid is
//               ignored for HOLDOFF cycles while the FIFO output re-qualifies.
// Ports   : clk and rst (async, active-high); iENABLE; iCUR_TIME (wrapping 44-bit time base);
//           fts is the FIFO head and release channel; oLATE is the late-capture pulse;
//           oREG_REL_CNT and oREG_LATE_CNT are saturating statistics.
module future_ts_release #(
  parameter int unsigned HOLDOFF     = 3,
  parameter logic [43:0] LATE_THRESH = 44'd16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iENABLE,
  input  logic [43:0]                iCUR_TIME,
  future_ts_release_if.master        fts,
  output logic                       oLATE,
  output logic [31:0]                oREG_REL_CNT,
  output logic [31:0]                oREG_LATE_CNT
);

  localparam logic [3:0] HOLDOFF_L = 4'(HOLDOFF);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_WAIT = 4'b0010,
    S_OUT  = 4'b0100,
    S_HOLD = 4'b1000
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  hold_cnt;
  logic [43:0] rel_time;
  logic [43:0] diff;
  logic        due;
  logic        late;
  logic        capture;
  logic        handshake;

  // Wrap-aware compare: the entry is due once cur - release is "non-negative"
  // in 44-bit two's complement.
  assign rel_time = fts.iFUTURE_TS[107:64];
  assign diff     = iCUR_TIME - rel_time;
  assign due      = ~diff[43];
  assign late     = due && (diff > LATE_THRESH);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (iENABLE && fts.iFTS_VALID) state_nxt = S_WAIT;
      S_WAIT: begin
        // A valid drop wins over a simultaneous due condition.
        if (!iENABLE || !fts.iFTS_VALID) state_nxt = S_IDLE;
        else if (due)                    state_nxt = S_OUT;
      end
      // A captured entry is always delivered, so iENABLE is not looked at here.
      S_OUT:  if (fts.iREL_READY) state_nxt = S_HOLD;
      S_HOLD: if (hold_cnt == 4'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output strobes; they feed the registered outputs below.
  always_comb begin
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      S_WAIT:  capture   = iENABLE && fts.iFTS_VALID && due;
      S_OUT:   handshake = fts.iREL_READY;
      default: ;
    endcase
  end

  // Registered outputs, holdoff counter and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fts.oTS_FIFO_POP <= 1'b0;
      fts.oREL_VALID   <= 1'b0;
      fts.oREL_TS      <= '0;
      fts.oREL_TAG     <= '0;
      oLATE            <= 1'b0;
      oREG_REL_CNT     <= '0;
      oREG_LATE_CNT    <= '0;
      hold_cnt         <= '0;
    end else begin
      fts.oTS_FIFO_POP <= capture;
      oLATE            <= capture && late;

      if (capture) begin
        fts.oREL_TS    <= rel_time;
        fts.oREL_TAG   <= fts.iFUTURE_TS[63:0];
        fts.oREL_VALID <= 1'b1;
        hold_cnt       <= HOLDOFF_L;
      end else if (hold_cnt != 4'd0) begin
        // Runs down through OUT and HOLD alike, so a slow handshake eats into the holdoff.
        hold_cnt <= hold_cnt - 4'd1;
      end

      if (handshake) fts.oREL_VALID <= 1'b0;

      if (handshake && (oREG_REL_CNT != 32'hFFFF_FFFF))
        oREG_REL_CNT <= oREG_REL_CNT + 32'd1;

      if (capture && late && (oREG_LATE_CNT != 32'hFFFF_FFFF))
        oREG_LATE_CNT <= oREG_LATE_CNT + 32'd1;
    end
  end

endmodule

// File: doc/future_ts_release.md
Name: future_ts_release

Overview:
- Downstream consumer of the timestamp FIFO stage: the time arbiter.
- Takes the 108-bit future timestamp entry and its valid qualifier and holds the entry until the local time reaches the entry's release time.
- At release it presents the entry on a ready/valid interface to the extractor-side scheduler, pops the FIFO, and masks the stale valid while the FIFO output pipeline refills.
- Also keeps release and late-release statistics for the register block.

Parameters:
- HOLDOFF, 3, cycles after a pop during which iFTS_VALID is ignored. Legal range 1..15; it covers the FIFO output re-qualification latency.
- LATE_THRESH, 44'd16, time units. A release whose time difference exceeds this value counts as late.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- iENABLE  in  1  block enable
- iCUR_TIME  in  44  global time base, free-running, wraps modulo 2^44
- iFUTURE_TS  in  108  FIFO head entry. [107:64] is the release time, [63:0] is the tag.
- iFTS_VALID  in  1  FIFO head entry is valid
- oTS_FIFO_POP  out  1  single-cycle pop pulse to the FIFO
- oREL_VALID  out  1  released entry valid
- oREL_TS  out  44  release time of the released entry
- oREL_TAG  out  64  tag of the released entry
- iREL_READY  in  1  downstream accepts the released entry
- oLATE  out  1  single-cycle pulse when a late release is captured
- oREG_REL_CNT  out  32  count of releases, saturating
- oREG_LATE_CNT  out  32  count of late releases, saturating

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - holdoff counter 0
- Time comparison:
  - diff = iCUR_TIME - iFUTURE_TS[107:64], computed modulo 2^44.
  - due = (diff[43] == 0). The comparison is wrap-aware and valid while the release time is within 2^43 of the current time.
  - late = due and diff > LATE_THRESH.
- State machine, one-hot, four states:
  - IDLE: go to WAIT when iENABLE=1 and iFTS_VALID=1.
  - WAIT:
    - If iENABLE=0 or iFTS_VALID=0, go to IDLE with no pop.
    - Else if due: register iFUTURE_TS into oREL_TS/oREL_TAG, pulse oTS_FIFO_POP for one cycle, load the holdoff counter with HOLDOFF, set oREL_VALID, pulse oLATE if late, and go to OUT.
    - Otherwise stay in WAIT.
  - OUT:
    - Hold oREL_VALID, oREL_TS and oREL_TAG stable until iREL_READY=1.
    - On the handshake cycle: clear oREL_VALID next cycle, increment oREG_REL_CNT, and go to HOLD.
    - iENABLE=0 does not abort OUT. An entry that has been captured is always delivered.
  - HOLD: go to IDLE when the holdoff counter is 0. iFTS_VALID is ignored.
- Holdoff counter:
  - Decrements every cycle while non-zero, in OUT and in HOLD alike.
  - If the handshake occurs after the counter has expired, HOLD lasts one cycle.
- Latency:
  - The due condition seen in WAIT at cycle N gives oREL_VALID=1 and oTS_FIFO_POP=1 at cycle N+1. Both are registered outputs.
  - From a zero-wait release back to IDLE takes at least max(HOLDOFF, 2) cycles.
- Pop rules:
  - Exactly one pop per release.
  - No pop in any state other than the WAIT-to-OUT transition.
  - No pop while iFTS_VALID=0.
- Counters:
  - oREG_LATE_CNT increments in the same cycle that oLATE pulses.
  - Both counters saturate at 32'hFFFF_FFFF and do not wrap.
  - Counters are cleared only by reset.
- Simultaneous events:
  - If due and iFTS_VALID fall together in WAIT, the iFTS_VALID=0 condition wins: no capture, go to IDLE.
- Reset mid-operation:
  - A reset asserted in any state returns the block to IDLE immediately and clears outputs and counters.
  - A pending oREL_VALID is dropped. No pop is generated on reset release.

Test Plan:
- Basic release, HOLDOFF=3: iFTS_VALID=1, release time=100, tag=64'hA5. Drive iCUR_TIME from 90 upward with iREL_READY=1. Required: one pop in the cycle after cur=100 is sampled; oREL_TS=100 and oREL_TAG=64'hA5 with oREL_VALID=1 for one cycle; oREG_REL_CNT=1; oLATE=0.
- Late release, LATE_THRESH=16: release time=50 arrives when cur=100. Required: immediate release with oLATE pulse; oREG_LATE_CNT=1; oREG_REL_CNT=1.
- Time wrap: release time=44'h000_0000_0004 with cur=44'hFFF_FFFF_FFFE counting up. Required: no release until cur=4, then release with oLATE=0.
- Backpressure plus holdoff: iREL_READY=0 for 10 cycles after release, with iFTS_VALID held at 1. Required: outputs stable for all 10 cycles; a single pop only; the next entry is evaluated no earlier than 1 cycle after the handshake.
- Abort and stale valid: iFTS_VALID drops in WAIT, or iENABLE=0 in WAIT. Required: no pop and return to IDLE. In a separate run, iFTS_VALID stays 1 during HOLDOFF=3 after a pop. Required: no second pop within 3 cycles.
- Reset mid-OUT: assert rst while oREL_VALID=1. Required: oREL_VALID=0, both counters 0, state IDLE, and no pop after reset deasserts until iFTS_VALID is high and the entry is due.
